// File: rtl/sched_pkg.sv
// sched_pkg: shared operand width, scheduler state enum and operand bundle for the complex multiplier scheduler
package sched_pkg;
  localparam int OVERALL_BITS = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
  typedef struct packed {
    logic [OVERALL_BITS-1:0] a_real;
    logic [OVERALL_BITS-1:0] a_imag;
    logic [OVERALL_BITS-1:0] b_real;
    logic [OVERALL_BITS-1:0] b_imag;
  } cmult_operands_t;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of issuing requester tags; push/din in, pop/dout out, count = entries held (0..DEPTH)
module tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign dout = mem[rd[AW-1:0]];
  assign count = wr - rd;
  always_ff @(posedge clk) if (push) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
    end
  end
endmodule

// File: rtl/complex_mult_scheduler.sv
// complex_mult_scheduler: round-robin sharing of one complex multiplier; req_* handshakes in, mul_* issue/result, rsp_* routed results, flush/idle/err_underflow control
module complex_mult_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][OVERALL_BITS-1:0]  req_a_real,
  input  logic [NUM_REQ-1:0][OVERALL_BITS-1:0]  req_a_imag,
  input  logic [NUM_REQ-1:0][OVERALL_BITS-1:0]  req_b_real,
  input  logic [NUM_REQ-1:0][OVERALL_BITS-1:0]  req_b_imag,
  output logic                                  mul_start,
  output logic [OVERALL_BITS-1:0]               mul_a_real,
  output logic [OVERALL_BITS-1:0]               mul_a_imag,
  output logic [OVERALL_BITS-1:0]               mul_b_real,
  output logic [OVERALL_BITS-1:0]               mul_b_imag,
  input  logic                                  mul_done,
  input  logic [OVERALL_BITS-1:0]               mul_res_real,
  input  logic [OVERALL_BITS-1:0]               mul_res_imag,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [OVERALL_BITS-1:0]               rsp_real,
  output logic [OVERALL_BITS-1:0]               rsp_imag,
  input  logic                                  flush,
  output logic                                  idle,
  output logic                                  err_underflow
);
  localparam int TW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  sched_state_t state;
  cmult_operands_t op;
  logic [TW-1:0] last_grant, gidx, tag;
  logic [CW-1:0] count;
  logic found, accept, pop;
  always_comb begin
    gidx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[TW'((int'(last_grant) + 1 + i) % NUM_REQ)]) begin
        found = 1'b1;
        gidx = TW'((int'(last_grant) + 1 + i) % NUM_REQ);
      end
    end
  end
  assign accept = state == RUN && !flush && count < CW'(TAG_DEPTH) && found;
  assign req_ready = accept ? NUM_REQ'(1) << gidx : '0;
  assign pop = mul_done && count != '0;
  assign idle = state == IDLE && count == '0;
  assign mul_a_real = op.a_real;
  assign mul_a_imag = op.a_imag;
  assign mul_b_real = op.b_real;
  assign mul_b_imag = op.b_imag;
  tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(TW)) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (gidx),
    .pop   (pop),
    .dout  (tag),
    .count (count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= TW'(NUM_REQ - 1);
      op <= '0;
      mul_start <= 1'b0;
      rsp_valid <= '0;
      rsp_real <= '0;
      rsp_imag <= '0;
      err_underflow <= 1'b0;
    end else begin
      mul_start <= accept;
      rsp_valid <= pop ? NUM_REQ'(1) << tag : '0;
      err_underflow <= err_underflow | (mul_done && count == '0);
      if (accept) begin
        last_grant <= gidx;
        op <= '{a_real: req_a_real[gidx], a_imag: req_a_imag[gidx], b_real: req_b_real[gidx], b_imag: req_b_imag[gidx]};
      end
      if (pop) begin
        rsp_real <= mul_res_real;
        rsp_imag <= mul_res_imag;
      end
      state <= state == IDLE ? (|req_valid && !flush ? RUN : IDLE)
             : state == RUN  ? (flush ? DRAIN : (!(|req_valid) && count == '0) ? IDLE : RUN)
             : (count == '0 && !flush) ? IDLE : DRAIN;
    end
  end
endmodule

// File: tb/tb_complex_mult_scheduler.sv
// tb_complex_mult_scheduler: randomized self-checking bench with a queue-based scheduler model and a latency-modelled datapath stub
module tb_complex_mult_scheduler;
  import sched_pkg::*;
  localparam int N = 2, D = 16, B = OVERALL_BITS;
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  typedef struct {int due; logic [B-1:0] re; logic [B-1:0] im;} dp_t;
  logic clk, rst_n, mul_start, mul_done, flush, idle, err_underflow;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N-1:0][B-1:0] req_a_real, req_a_imag, req_b_real, req_b_imag;
  logic [B-1:0] mul_a_real, mul_a_imag, mul_b_real, mul_b_imag, mul_res_real, mul_res_imag, rsp_real, rsp_imag;
  int checks = 0, failures = 0, cyc = 0, lat = 6, starts = 0;
  bit dp_hold = 0, spur = 0, rnd_lat = 0;
  mstate_t ms;
  int lg;
  int tags[$], grants[$], rsps[$];
  dp_t dpq[$];
  bit e_start, e_err;
  logic [N-1:0] e_rsp;
  logic [B-1:0] e_op [4];
  logic [B-1:0] e_rr, e_ri;
  complex_mult_scheduler #(.NUM_REQ(N), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_real(req_a_real), .req_a_imag(req_a_imag), .req_b_real(req_b_real), .req_b_imag(req_b_imag),
    .mul_start(mul_start), .mul_a_real(mul_a_real), .mul_a_imag(mul_a_imag), .mul_b_real(mul_b_real), .mul_b_imag(mul_b_imag),
    .mul_done(mul_done), .mul_res_real(mul_res_real), .mul_res_imag(mul_res_imag),
    .rsp_valid(rsp_valid), .rsp_real(rsp_real), .rsp_imag(rsp_imag),
    .flush(flush), .idle(idle), .err_underflow(err_underflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [B-1:0] prod(bit im, logic [B-1:0] ar, logic [B-1:0] ai, logic [B-1:0] br, logic [B-1:0] bi);
    longint r;
    r = im ? longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br))
           : longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
    return B'(r >>> 8);
  endfunction
  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a_real[i] = B'($urandom);
      req_a_imag[i] = B'($urandom);
      req_b_real[i] = B'($urandom);
      req_b_imag[i] = B'($urandom);
    end
  endtask
  task automatic model_reset();
    ms = M_IDLE;
    lg = N - 1;
    tags.delete();
    e_start = 0;
    e_err = 0;
    e_rsp = '0;
    e_op = '{default: '0};
    e_rr = '0;
    e_ri = '0;
  endtask
  task automatic do_reset();
    mul_done = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err_underflow, 0);
    chk("rst_mul_ops", {mul_a_real, mul_a_imag, mul_b_real, mul_b_imag}, 0);
    chk("rst_rsp_data", {rsp_real, rsp_imag}, 0);
    model_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask
  task automatic cycle();
    int w, c0;
    logic [N-1:0] er;
    mul_done = 1'b0;
    if (!dp_hold && dpq.size() > 0 && dpq[0].due <= cyc) begin
      mul_done = 1'b1;
      mul_res_real = dpq[0].re;
      mul_res_imag = dpq[0].im;
      dpq.delete(0);
    end else if (spur) begin
      mul_done = 1'b1;
      mul_res_real = B'($urandom);
      mul_res_imag = B'($urandom);
    end
    c0 = tags.size();
    w = -1;
    if (ms == M_RUN && !flush && c0 < D)
      for (int i = 0; i < N; i++) if (w < 0 && req_valid[(lg + 1 + i) % N]) w = (lg + 1 + i) % N;
    er = (w < 0) ? '0 : N'(1) << w;
    #1;
    chk("req_ready", req_ready, er);
    e_start = w >= 0;
    e_rsp = '0;
    if (w >= 0) begin
      e_op = '{req_a_real[w], req_a_imag[w], req_b_real[w], req_b_imag[w]};
      tags.push_back(w);
      grants.push_back(w);
      lg = w;
    end
    if (mul_done) begin
      if (c0 == 0) e_err = 1;
      else begin
        e_rsp = N'(1) << tags.pop_front();
        e_rr = mul_res_real;
        e_ri = mul_res_imag;
      end
    end
    case (ms)
      M_IDLE:  if (|req_valid && !flush) ms = M_RUN;
      M_RUN:   if (flush) ms = M_DRAIN; else if (req_valid == 0 && c0 == 0) ms = M_IDLE;
      default: if (c0 == 0 && !flush) ms = M_IDLE;
    endcase
    @(negedge clk);
    cyc++;
    chk("mul_start", mul_start, e_start);
    chk("mul_ops", {mul_a_real, mul_a_imag, mul_b_real, mul_b_imag}, {e_op[0], e_op[1], e_op[2], e_op[3]});
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("rsp_data", {rsp_real, rsp_imag}, {e_rr, e_ri});
    chk("err_underflow", err_underflow, e_err);
    chk("idle", idle, ms == M_IDLE && tags.size() == 0);
    if (mul_start) begin
      starts++;
      dpq.push_back('{cyc + (rnd_lat ? int'($urandom_range(1, 8)) : lat),
                      prod(0, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag),
                      prod(1, mul_a_real, mul_a_imag, mul_b_real, mul_b_imag)});
    end
    if (rsp_valid != 0) rsps.push_back(rsp_valid == 2'b01 ? 0 : rsp_valid == 2'b10 ? 1 : 2);
  endtask
  task automatic drain(int n);
    for (int i = 0; i < n && !(idle && dpq.size() == 0); i++) cycle();
    chk("drained_idle", idle && dpq.size() == 0, 1);
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    mul_done = 1'b0;
    mul_res_real = '0;
    mul_res_imag = '0;
    req_a_real = '0;
    req_a_imag = '0;
    req_b_real = '0;
    req_b_imag = '0;
    @(negedge clk);
    do_reset();
    req_valid = 2'b01;
    req_a_real[0] = 16'h0100;
    req_a_imag[0] = 16'h0200;
    req_b_real[0] = 16'h0300;
    req_b_imag[0] = 16'h0400;
    for (int i = 0; i < 10 && grants.size() == 0; i++) cycle();
    req_valid = '0;
    for (int i = 0; i < 20 && rsps.size() == 0; i++) cycle();
    chk("single_rsp_count", rsps.size(), 1);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_value", {rsp_real, rsp_imag}, 32'hFB00_0A00);
    drain(20);
    do_reset();
    grants.delete();
    rsps.delete();
    req_valid = '1;
    for (int i = 0; i < 20 && grants.size() < 8; i++) begin rand_ops(); cycle(); end
    req_valid = '0;
    drain(40);
    chk("fair_grants", grants.size(), 8);
    chk("fair_rsps", rsps.size(), 8);
    for (int i = 0; i < grants.size(); i++) chk("fair_order", grants[i], i % 2);
    for (int i = 0; i < rsps.size() && i < grants.size(); i++) chk("fair_route", rsps[i], grants[i]);
    do_reset();
    grants.delete();
    rsps.delete();
    dp_hold = 1;
    req_valid = '1;
    for (int i = 0; i < 40 && grants.size() < 16; i++) begin rand_ops(); cycle(); end
    chk("full_grants", grants.size(), 16);
    repeat (3) begin rand_ops(); cycle(); end
    chk("full_blocked", grants.size(), 16);
    dp_hold = 0;
    rand_ops(); cycle();
    rand_ops(); cycle();
    dp_hold = 1;
    rand_ops(); cycle();
    rand_ops(); cycle();
    chk("full_refill", grants.size(), 18);
    req_valid = '0;
    dp_hold = 0;
    drain(60);
    chk("full_rsps", rsps.size(), 18);
    do_reset();
    grants.delete();
    rsps.delete();
    starts = 0;
    lat = 10;
    req_valid = '1;
    for (int i = 0; i < 20 && grants.size() < 5; i++) begin rand_ops(); cycle(); end
    flush = 1'b1;
    for (int i = 0; i < 40 && rsps.size() < 5; i++) begin rand_ops(); cycle(); end
    cycle();
    cycle();
    chk("flush_hold_busy", idle, 0);
    flush = 1'b0;
    req_valid = '0;
    cycle();
    cycle();
    chk("flush_idle", idle, 1);
    chk("flush_grants", grants.size(), 5);
    chk("flush_starts", starts, 5);
    chk("flush_rsps", rsps.size(), 5);
    do_reset();
    lat = 6;
    spur = 1;
    cycle();
    spur = 0;
    chk("uf_idle_err", err_underflow, 1);
    grants.delete();
    rsps.delete();
    req_valid = '1;
    for (int i = 0; i < 10 && grants.size() < 3; i++) begin rand_ops(); cycle(); end
    req_valid = '0;
    cycle();
    cycle();
    do_reset();
    for (int i = 0; i < 20 && dpq.size() > 0; i++) cycle();
    cycle();
    chk("uf_late_err", err_underflow, 1);
    chk("uf_no_rsp", rsps.size(), 0);
    do_reset();
    rnd_lat = 1;
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      flush = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 31) == 0) dp_hold = ~dp_hold;
      rand_ops();
      cycle();
    end
    flush = 1'b0;
    req_valid = '0;
    dp_hold = 0;
    drain(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
